// File: rtl/clkdiv_prog.sv
// clkdiv_prog: multi-channel programmable clock divider with per-channel
// glitch-free divisor updates; defining CLKDIV_SYNC_EN adds the sync input.
module clkdiv_prog #(
  parameter int CH       = 2,
  parameter int WIDTH    = 26,
  parameter int DEF_DIV  = 25000000,
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic [CH-1:0]    clk_slow,
  output logic [CH-1:0]    tick
);

  localparam int NP = 1 << CW;
  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEF_DIV);

  logic [WIDTH-1:0] cnt_r      [CH];
  logic [WIDTH-1:0] div_cur_r  [CH];
  logic [WIDTH-1:0] div_pend_r [CH];
  logic [CH-1:0]    pending_r;
  logic [CH-1:0]    clk_slow_r;
  logic [CH-1:0]    tick_r;
  logic [CH-1:0]    comp_s;
  logic [CH-1:0]    clear_s;
  logic [CH-1:0]    apply_s;
  logic [CH-1:0]    wr_s;
  logic [NP-1:0]    pend_pad_s;
  logic [WIDTH-1:0] div_eff_s;
  logic             xfer_s;

  // Ready drops only while the addressed channel holds an unapplied update;
  // out-of-range channels read as zero-padded and are always ready.
  always_comb begin
    pend_pad_s = NP'(pending_r);
    cfg_ready  = ~pend_pad_s[cfg_ch];
  end

  // Wrap detection, config decode and update-apply qualification per channel
  always_comb begin
    xfer_s    = cfg_valid & cfg_ready;
    div_eff_s = (cfg_div == ZERO_W) ? ONE_W : cfg_div;
    comp_s    = {CH{1'b0}};
    clear_s   = {CH{1'b0}};
    apply_s   = {CH{1'b0}};
    wr_s      = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      comp_s[i]  = en[i] & (cnt_r[i] == (div_cur_r[i] - ONE_W));
`ifdef CLKDIV_SYNC_EN
      clear_s[i] = sync | ~en[i];
`else
      clear_s[i] = ~en[i];
`endif
      // pending_r is sampled before any same-cycle write, so a transfer that
      // lands on a wrap waits for the following wrap
      apply_s[i] = pending_r[i] & (clear_s[i] | comp_s[i]);
      wr_s[i]    = xfer_s & (32'(cfg_ch) == i);
    end
  end

  // Channel counters, output levels and divisor/pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        cnt_r[i]      <= ZERO_W;
        div_cur_r[i]  <= DEF_W;
        div_pend_r[i] <= DEF_W;
      end
      pending_r  <= {CH{1'b0}};
      clk_slow_r <= {CH{1'b0}};
      tick_r     <= {CH{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (clear_s[i]) begin
          cnt_r[i]      <= ZERO_W;
          clk_slow_r[i] <= 1'b0;
          tick_r[i]     <= 1'b0;
        end else if (comp_s[i]) begin
          cnt_r[i]      <= ZERO_W;
          clk_slow_r[i] <= ~clk_slow_r[i];
          tick_r[i]     <= 1'b1;
        end else begin
          cnt_r[i]      <= cnt_r[i] + ONE_W;
          tick_r[i]     <= 1'b0;
        end
        if (apply_s[i]) begin
          div_cur_r[i] <= div_pend_r[i];
        end
        if (wr_s[i]) begin
          div_pend_r[i] <= div_eff_s;
          pending_r[i]  <= 1'b1;
        end else if (apply_s[i]) begin
          pending_r[i]  <= 1'b0;
        end
      end
    end
  end

  assign clk_slow = clk_slow_r;
  assign tick     = tick_r;

endmodule
